// File: rtl/mania_pixel_gen.sv
// Pixel source for the 4-lane rhythm display: falling-note lanes, key judging and hit/miss counters.
// Latency: colour registered one cycle after row_addr/col_addr; judge/scroll take effect on the next edge.
// Backpressure: none; note_valid spawns are always accepted and the VGA read strobe is never stalled.
module mania_pixel_gen #(
    parameter int SCROLL_FRAMES = 2,
    parameter int LANE_X0       = 192,
    parameter int LANE_W        = 64,
    parameter int CELL_H        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    input  logic [3:0]  key,
    input  logic [3:0]  note_in,
    input  logic        note_valid,
    output logic [3:0]  color_r,
    output logic [3:0]  color_g,
    output logic [3:0]  color_b,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int        LW_SH   = $clog2(LANE_W);
    localparam int        CH_SH   = $clog2(CELL_H);
    localparam int        FC_W    = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [9:0] X_START = 10'(LANE_X0);
    localparam logic [9:0] X_END   = 10'(LANE_X0 + 4 * LANE_W);
    localparam logic [8:0] KEY_ROW = 9'(480 - CELL_H);

    logic [3:0]      key_s1, key_s2, key_prev, press;
    logic            frame_tick, shift;
    logic [FC_W-1:0] frame_cnt;
    logic [29:0]     lane_q [4];
    logic [29:0]     judged [4];
    logic [3:0]      pending, hit_v, miss_v;

    logic [9:0]  rel;
    logic [1:0]  lane_idx;
    logic [4:0]  cell_idx;
    logic        in_lanes, boundary, note_here;
    logic [11:0] pix;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] n);
        logic [16:0] s;
        s = {1'b0, a} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign press = key_s2 & ~key_prev;
    assign shift = frame_tick && (frame_cnt == FC_W'(SCROLL_FRAMES - 1));

    // Judging works on the pre-shift lane so a cleared hit-line note never scores as a miss.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            judged[i] = lane_q[i];
            hit_v[i]  = 1'b0;
            if (press[i] && lane_q[i][29]) begin
                judged[i][29] = 1'b0;
                hit_v[i]      = 1'b1;
            end else if (press[i] && lane_q[i][28]) begin
                judged[i][28] = 1'b0;
                hit_v[i]      = 1'b1;
            end
            miss_v[i] = shift && judged[i][29];
        end
    end

    always_comb begin
        rel       = col_addr - X_START;
        in_lanes  = (col_addr >= X_START) && (col_addr < X_END);
        boundary  = (in_lanes && ((rel & 10'(LANE_W - 1)) == 10'd0)) || (col_addr == X_END);
        lane_idx  = 2'(rel >> LW_SH);
        cell_idx  = 5'(row_addr >> CH_SH);
        note_here = in_lanes && (cell_idx < 5'd30) && lane_q[lane_idx][cell_idx];
        pix       = 12'h000;
        if (boundary) begin
            pix = 12'h888;
        end else if (note_here) begin
            case (lane_idx)
                2'd0:    pix = 12'hF00;
                2'd1:    pix = 12'h0F0;
                2'd2:    pix = 12'h00F;
                default: pix = 12'hFF0;
            endcase
        end else if (in_lanes && row_addr >= KEY_ROW) begin
            pix = key_s2[lane_idx] ? 12'hFFF : 12'h444;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1     <= '0;
            key_s2     <= '0;
            key_prev   <= '0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
            pending    <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            color_r    <= '0;
            color_g    <= '0;
            color_b    <= '0;
            for (int i = 0; i < 4; i++) lane_q[i] <= '0;
        end else begin
            key_s1     <= key;
            key_s2     <= key_s1;
            key_prev   <= key_s2;
            frame_tick <= !rdn && (row_addr == 9'd479) && (col_addr == 10'd639);
            if (frame_tick)
                frame_cnt <= (frame_cnt == FC_W'(SCROLL_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
            pending  <= shift ? 4'b0 : (pending | (note_valid ? note_in : 4'b0));
            hit_cnt  <= sat_add(hit_cnt, popcnt4(hit_v));
            miss_cnt <= sat_add(miss_cnt, popcnt4(miss_v));
            for (int i = 0; i < 4; i++) begin
                if (shift)
                    lane_q[i] <= {judged[i][28:0], pending[i] | (note_valid & note_in[i])};
                else
                    lane_q[i] <= judged[i];
            end
            {color_r, color_g, color_b} <= rdn ? 12'h000 : pix;
        end
    end
endmodule

// File: tb/tb_mania_pixel_gen.sv
// Directed bench for mania_pixel_gen: pixel table after a spawn plus hand sequences for miss, hit, race and reset.
module tb_mania_pixel_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic [3:0]  key;
    logic [3:0]  note_in;
    logic        note_valid;
    logic [3:0]  color_r, color_g, color_b;
    logic [15:0] hit_cnt, miss_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic [8:0] row;
        logic [9:0] col;
        logic       rd;
        logic [11:0] exp;
    } pix_vec_t;

    pix_vec_t vt [11];

    mania_pixel_gen dut (
        .clk(clk), .rst(rst), .row_addr(row_addr), .col_addr(col_addr), .rdn(rdn),
        .key(key), .note_in(note_in), .note_valid(note_valid),
        .color_r(color_r), .color_g(color_g), .color_b(color_b),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic frame();
        row_addr = 9'd479; col_addr = 10'd639; rdn = 1'b0;
        step();
        rdn = 1'b1; row_addr = '0; col_addr = '0;
        step();
    endtask

    task automatic shifts(input int n);
        repeat (2 * n) frame();
    endtask

    task automatic spawn(input logic [3:0] m);
        note_in = m; note_valid = 1'b1;
        step();
        note_valid = 1'b0; note_in = '0;
    endtask

    task automatic read_px(input logic [8:0] r, input logic [9:0] c, input logic rd,
                           output logic [11:0] px);
        row_addr = r; col_addr = c; rdn = rd;
        step();
        px = {color_r, color_g, color_b};
        rdn = 1'b1;
    endtask

    task automatic press_key(input int lane);
        key[lane] = 1'b1;
        repeat (4) step();
        key[lane] = 1'b0;
        repeat (4) step();
    endtask

    task automatic expect_px(input string name, input logic [8:0] r, input logic [9:0] c,
                             input logic [11:0] exp);
        logic [11:0] px;
        read_px(r, c, 1'b0, px);
        check(name, {4'h0, px}, {4'h0, exp});
    endtask

    initial begin
        vt[0]  = '{"l0_cell0_left",   9'd0,   10'd193, 1'b0, 12'hF00};
        vt[1]  = '{"l0_cell0_corner", 9'd15,  10'd255, 1'b0, 12'hF00};
        vt[2]  = '{"l0_cell1_empty",  9'd16,  10'd200, 1'b0, 12'h000};
        vt[3]  = '{"bnd_192",         9'd0,   10'd192, 1'b0, 12'h888};
        vt[4]  = '{"bnd_256",         9'd0,   10'd256, 1'b0, 12'h888};
        vt[5]  = '{"bnd_448",         9'd100, 10'd448, 1'b0, 12'h888};
        vt[6]  = '{"l1_empty",        9'd0,   10'd257, 1'b0, 12'h000};
        vt[7]  = '{"out_left",        9'd0,   10'd100, 1'b0, 12'h000};
        vt[8]  = '{"out_right",       9'd0,   10'd449, 1'b0, 12'h000};
        vt[9]  = '{"rdn_high",        9'd0,   10'd193, 1'b1, 12'h000};
        vt[10] = '{"keyrow_idle",     9'd470, 10'd300, 1'b0, 12'h444};

        rst = 1'b1; row_addr = '0; col_addr = '0; rdn = 1'b1;
        key = '0; note_in = '0; note_valid = 1'b0;
        step(); step();
        check("rst_hit", hit_cnt, 16'd0);
        check("rst_miss", miss_cnt, 16'd0);
        check("rst_color", {4'h0, color_r, color_g, color_b}, 16'h0);
        rst = 1'b0;
        step();

        // spawn lane 0: only the second frame tick scrolls it in
        spawn(4'b0001);
        frame();
        expect_px("no_shift_after_1_frame", 9'd0, 10'd193, 12'h000);
        frame();
        for (int i = 0; i < 11; i++) begin
            logic [11:0] px;
            read_px(vt[i].row, vt[i].col, vt[i].rd, px);
            check(vt[i].name, {4'h0, px}, {4'h0, vt[i].exp});
        end

        // miss: fall to the hit line, then off the bottom
        shifts(29);
        expect_px("l0_cell29", 9'd470, 10'd200, 12'hF00);
        shifts(1);
        check("miss_after_fall", miss_cnt, 16'd1);
        check("hit_after_fall", hit_cnt, 16'd0);
        expect_px("l0_empty_bottom", 9'd470, 10'd200, 12'h444);

        // hit on lane 2 at cell 29, then a penalty-free second press
        spawn(4'b0100);
        shifts(30);
        expect_px("l2_cell29", 9'd470, 10'd330, 12'h00F);
        press_key(2);
        check("hit_l2", hit_cnt, 16'd1);
        expect_px("l2_cleared", 9'd470, 10'd330, 12'h444);
        press_key(2);
        check("hit_l2_repress", hit_cnt, 16'd1);
        check("miss_l2", miss_cnt, 16'd1);

        // race: lane 1 press lands on the same edge as the scrolling shift
        spawn(4'b0010);
        shifts(30);
        expect_px("l1_cell29", 9'd470, 10'd270, 12'h0F0);
        frame();
        key[1] = 1'b1;
        step();
        row_addr = 9'd479; col_addr = 10'd639; rdn = 1'b0;
        step();
        rdn = 1'b1; row_addr = '0; col_addr = '0;
        step();
        key[1] = 1'b0;
        repeat (4) step();
        check("race_hit", hit_cnt, 16'd2);
        check("race_miss", miss_cnt, 16'd1);
        expect_px("race_cleared", 9'd470, 10'd270, 12'h444);

        // lane 3 note at cell 28 cleared by a held key; key row shows white
        spawn(4'b1000);
        shifts(29);
        expect_px("l3_cell28", 9'd450, 10'd400, 12'hFF0);
        key[3] = 1'b1;
        repeat (4) step();
        expect_px("key3_held", 9'd470, 10'd400, 12'hFFF);
        expect_px("l3_cell28_cleared", 9'd450, 10'd400, 12'h000);
        key[3] = 1'b0;
        repeat (4) step();
        check("hit_cell28", hit_cnt, 16'd3);
        check("miss_cell28", miss_cnt, 16'd1);

        // reset mid-frame with a note present
        spawn(4'b0001);
        shifts(1);
        expect_px("pre_reset_note", 9'd0, 10'd193, 12'hF00);
        row_addr = 9'd100; col_addr = 10'd300; rdn = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("mid_rst_hit", hit_cnt, 16'd0);
        check("mid_rst_miss", miss_cnt, 16'd0);
        check("mid_rst_color", {4'h0, color_r, color_g, color_b}, 16'h0);
        rst = 1'b0; rdn = 1'b1;
        step();
        expect_px("post_reset_empty", 9'd0, 10'd193, 12'h000);
        shifts(1);
        expect_px("post_reset_no_pending", 9'd0, 10'd193, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
